// File: rtl/irq_priority_resolver_if.sv
// Request/acknowledge bundle between the interrupt control logic (master)
// and the priority resolver (slave).
interface irq_priority_resolver_if;
   logic [7:0] ir_in;
   logic       ltim;
   logic [7:0] imr;
   logic       inta_pulse;
   logic       eoi_nonspec;
   logic       eoi_spec;
   logic [2:0] eoi_level;
   logic       rotate;
   logic       auto_eoi;
   logic [7:0] irr;
   logic [7:0] isr;
   logic       int_req;
   logic [2:0] vector_id;
   logic       vector_valid;

   modport master (
      output ir_in, ltim, imr, inta_pulse, eoi_nonspec, eoi_spec, eoi_level, rotate, auto_eoi,
      input  irr, isr, int_req, vector_id, vector_valid
   );

   modport slave (
      input  ir_in, ltim, imr, inta_pulse, eoi_nonspec, eoi_spec, eoi_level, rotate, auto_eoi,
      output irr, isr, int_req, vector_id, vector_valid
   );
endinterface

// File: rtl/irq_priority_resolver.sv
// Interrupt request/priority stage: synchronises IR lines, keeps IRR/ISR,
// resolves fully-nested or rotating priority and serves the INTA pair.
module irq_priority_resolver #(
   parameter int         SYNC_STAGES       = 2,
   parameter logic [2:0] RESET_LOWEST_PRIO = 3'd7
) (
   input  logic                   clk,
   input  logic                   rst_n,
   irq_priority_resolver_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, ACK1 = 1'b1} state_t;

   // Returns {found, index} of the highest-priority set bit; priority starts
   // at low+1 and descends around the 3-bit ring.
   function automatic logic [3:0] top_of(input logic [7:0] vec, input logic [2:0] low);
      logic [2:0] idx;
      top_of = 4'b0;
      for (int k = 7; k >= 0; k--) begin
         idx = low + 3'(k + 1);
         if (vec[idx]) top_of = {1'b1, idx};
      end
   endfunction

   // 0 = highest priority, 7 = lowest
   function automatic logic [2:0] rank_of(input logic [2:0] idx, input logic [2:0] low);
      rank_of = idx - low - 3'd1;
   endfunction

   logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
   logic [7:0] ir_prev_q, ir_prev_d;
   logic [7:0] irr_q, irr_d;
   logic [7:0] isr_q, isr_d;
   logic       int_req_q, int_req_d;
   logic [2:0] vector_id_q, vector_id_d;
   logic       vector_valid_q, vector_valid_d;
   logic [2:0] lowest_q, lowest_d;
   logic       spurious_q, spurious_d;
   state_t     state_q, state_d;

   logic [7:0] ir_s, rise, pend, isr_set, isr_clr;
   logic [3:0] pend_top, isr_top;
   logic       idle, ack1, ack2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q         <= '0;
         ir_prev_q      <= 8'h00;
         irr_q          <= 8'h00;
         isr_q          <= 8'h00;
         int_req_q      <= 1'b0;
         vector_id_q    <= 3'd0;
         vector_valid_q <= 1'b0;
         lowest_q       <= RESET_LOWEST_PRIO;
         spurious_q     <= 1'b0;
         state_q        <= IDLE;
      end else begin
         sync_q         <= sync_d;
         ir_prev_q      <= ir_prev_d;
         irr_q          <= irr_d;
         isr_q          <= isr_d;
         int_req_q      <= int_req_d;
         vector_id_q    <= vector_id_d;
         vector_valid_q <= vector_valid_d;
         lowest_q       <= lowest_d;
         spurious_q     <= spurious_d;
         state_q        <= state_d;
      end
   end

   always_comb begin
      sync_d[0] = bus.ir_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
   end

   assign ir_s     = sync_q[SYNC_STAGES-1];
   assign rise     = ir_s & ~ir_prev_q;
   assign pend     = irr_q & ~bus.imr;
   assign pend_top = top_of(pend, lowest_q);
   assign isr_top  = top_of(isr_q, lowest_q);
   assign idle     = (state_q == IDLE);
   assign ack1     = idle & bus.inta_pulse;
   assign ack2     = !idle & bus.inta_pulse;

   always_comb begin
      state_d        = state_q;
      ir_prev_d      = ir_s;
      isr_set        = 8'h00;
      isr_clr        = 8'h00;
      lowest_d       = lowest_q;
      vector_id_d    = vector_id_q;
      spurious_d     = spurious_q;
      vector_valid_d = ack2;

      if (bus.inta_pulse) state_d = idle ? ACK1 : IDLE;

      // Edge mode: a request withdrawn while IDLE is dropped; once ACK1 starts the winner is frozen.
      if (bus.ltim) irr_d = ir_s;
      else          irr_d = (irr_q | rise) & (idle ? ir_s : 8'hFF);

      if (ack1) begin
         if (pend_top[3]) begin
            isr_set[pend_top[2:0]] = 1'b1;
            irr_d[pend_top[2:0]]   = 1'b0;
            vector_id_d            = pend_top[2:0];
            spurious_d             = 1'b0;
         end else begin
            vector_id_d = 3'd7;
            spurious_d  = 1'b1;
         end
      end

      if (bus.eoi_spec) begin
         isr_clr[bus.eoi_level] = 1'b1;
         if (bus.rotate) lowest_d = bus.eoi_level;
      end else if (bus.eoi_nonspec && isr_top[3]) begin
         isr_clr[isr_top[2:0]] = 1'b1;
         if (bus.rotate) lowest_d = isr_top[2:0];
      end

      if (ack2 && bus.auto_eoi && !spurious_q) begin
         isr_clr[vector_id_q] = 1'b1;
         if (bus.rotate) lowest_d = vector_id_q;
      end

      // A bit being set by INTA survives a same-cycle EOI clear.
      isr_d = (isr_q & ~isr_clr) | isr_set;

      int_req_d = pend_top[3] && !ack1 &&
                  (!isr_top[3] || (rank_of(pend_top[2:0], lowest_q) < rank_of(isr_top[2:0], lowest_q)));
   end

   assign bus.irr          = irr_q;
   assign bus.isr          = isr_q;
   assign bus.int_req      = int_req_q;
   assign bus.vector_id    = vector_id_q;
   assign bus.vector_valid = vector_valid_q;

endmodule

// File: tb/tb_irq_priority_resolver.sv
// Directed bench for irq_priority_resolver: a level-mode priority table plus
// hand-written edge-mode sequences for nesting, rotation, spurious INTA and reset.
module tb_irq_priority_resolver;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   irq_priority_resolver_if bus ();

   irq_priority_resolver #(.SYNC_STAGES(2), .RESET_LOWEST_PRIO(3'd7)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] ir;
      logic [7:0] imr;
      logic       exp_req;
      logic [2:0] exp_vid;
      logic [7:0] exp_isr;
   } vec_t;

   vec_t tbl [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_int(input string name, input int budget);
      int n = 0;
      while (bus.int_req !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check(name, {31'd0, bus.int_req}, 32'd1);
   endtask

   task automatic inta();
      bus.inta_pulse = 1'b1;
      tick();
      bus.inta_pulse = 1'b0;
   endtask

   task automatic eoi_ns(input logic rot);
      bus.eoi_nonspec = 1'b1;
      bus.rotate      = rot;
      tick();
      bus.eoi_nonspec = 1'b0;
      bus.rotate      = 1'b0;
   endtask

   task automatic eoi_sp(input logic [2:0] lvl);
      bus.eoi_spec  = 1'b1;
      bus.eoi_level = lvl;
      tick();
      bus.eoi_spec  = 1'b0;
      bus.eoi_level = 3'd0;
   endtask

   task automatic do_reset(input logic lt);
      rst_n           = 1'b0;
      bus.ir_in       = 8'h00;
      bus.ltim        = lt;
      bus.imr         = 8'h00;
      bus.inta_pulse  = 1'b0;
      bus.eoi_nonspec = 1'b0;
      bus.eoi_spec    = 1'b0;
      bus.eoi_level   = 3'd0;
      bus.rotate      = 1'b0;
      bus.auto_eoi    = 1'b0;
      ticks(2);
      check("rst_irr", {24'd0, bus.irr}, 32'h0);
      check("rst_isr", {24'd0, bus.isr}, 32'h0);
      check("rst_int_req", {31'd0, bus.int_req}, 32'h0);
      check("rst_vector_id", {29'd0, bus.vector_id}, 32'h0);
      check("rst_vector_valid", {31'd0, bus.vector_valid}, 32'h0);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{8'h01, 8'h00, 1'b1, 3'd0, 8'h01};
      tbl[1] = '{8'h80, 8'h00, 1'b1, 3'd7, 8'h80};
      tbl[2] = '{8'h90, 8'h00, 1'b1, 3'd4, 8'h10};
      tbl[3] = '{8'hFF, 8'h01, 1'b1, 3'd1, 8'h02};
      tbl[4] = '{8'h0C, 8'h04, 1'b1, 3'd3, 8'h08};
      tbl[5] = '{8'h20, 8'h20, 1'b0, 3'd7, 8'h00};
      tbl[6] = '{8'hC0, 8'h80, 1'b1, 3'd6, 8'h40};

      // Level-triggered priority table, fixed priority (IR0 highest)
      do_reset(1'b1);
      for (int r = 0; r < 7; r++) begin
         bus.imr   = tbl[r].imr;
         bus.ir_in = tbl[r].ir;
         ticks(5);
         check($sformatf("tbl%0d_int_req", r), {31'd0, bus.int_req}, {31'd0, tbl[r].exp_req});
         check($sformatf("tbl%0d_irr", r), {24'd0, bus.irr}, {24'd0, tbl[r].ir});
         inta();
         check($sformatf("tbl%0d_vector_id", r), {29'd0, bus.vector_id}, {29'd0, tbl[r].exp_vid});
         check($sformatf("tbl%0d_isr", r), {24'd0, bus.isr}, {24'd0, tbl[r].exp_isr});
         inta();
         check($sformatf("tbl%0d_vector_valid", r), {31'd0, bus.vector_valid}, 32'd1);
         eoi_ns(1'b0);
         bus.ir_in = 8'h00;
         bus.imr   = 8'h00;
         ticks(5);
         check($sformatf("tbl%0d_isr_cleared", r), {24'd0, bus.isr}, 32'h0);
      end

      // Edge mode single request on IR3
      do_reset(1'b0);
      bus.ir_in = 8'h08;
      wait_int("ir3_int_req", 5);
      inta();
      check("ir3_isr", {24'd0, bus.isr}, 32'h08);
      check("ir3_irr", {24'd0, bus.irr}, 32'h00);
      check("ir3_vector_id", {29'd0, bus.vector_id}, 32'd3);
      check("ir3_int_req_dropped", {31'd0, bus.int_req}, 32'd0);
      check("ir3_vv_not_yet", {31'd0, bus.vector_valid}, 32'd0);
      inta();
      check("ir3_vv_pulse", {31'd0, bus.vector_valid}, 32'd1);
      tick();
      check("ir3_vv_one_cycle", {31'd0, bus.vector_valid}, 32'd0);
      check("ir3_isr_held", {24'd0, bus.isr}, 32'h08);

      // IR2 and IR5 together: IR2 first, IR5 after a specific EOI
      do_reset(1'b0);
      bus.ir_in = 8'h24;
      wait_int("pair_int_req", 5);
      inta();
      check("pair_first_vid", {29'd0, bus.vector_id}, 32'd2);
      check("pair_first_isr", {24'd0, bus.isr}, 32'h04);
      inta();
      ticks(2);
      check("pair_ir5_blocked", {31'd0, bus.int_req}, 32'd0);
      eoi_sp(3'd2);
      check("pair_isr_after_eoi", {24'd0, bus.isr}, 32'h00);
      wait_int("pair_second_int_req", 3);
      inta();
      check("pair_second_vid", {29'd0, bus.vector_id}, 32'd5);
      check("pair_second_isr", {24'd0, bus.isr}, 32'h20);
      inta();
      check("pair_second_vv", {31'd0, bus.vector_valid}, 32'd1);

      // Fully nested: IR2 in service, IR6 blocked, IR1 nests
      do_reset(1'b0);
      bus.ir_in = 8'h04;
      wait_int("nest_ir2_req", 5);
      inta();
      inta();
      check("nest_isr", {24'd0, bus.isr}, 32'h04);
      bus.ir_in = 8'h44;
      ticks(5);
      check("nest_ir6_irr", {24'd0, bus.irr}, 32'h40);
      check("nest_ir6_no_req", {31'd0, bus.int_req}, 32'd0);
      bus.ir_in = 8'h46;
      wait_int("nest_ir1_req", 6);
      inta();
      check("nest_ir1_vid", {29'd0, bus.vector_id}, 32'd1);
      check("nest_ir1_isr", {24'd0, bus.isr}, 32'h06);
      inta();

      // Rotation: after servicing IR4 with rotating EOI, IR5 outranks IR0
      do_reset(1'b0);
      bus.ir_in = 8'h10;
      wait_int("rot_ir4_req", 5);
      inta();
      check("rot_ir4_vid", {29'd0, bus.vector_id}, 32'd4);
      inta();
      eoi_ns(1'b1);
      check("rot_isr_cleared", {24'd0, bus.isr}, 32'h00);
      bus.ir_in = 8'h00;
      ticks(4);
      bus.ir_in = 8'h21;
      wait_int("rot_pair_req", 5);
      inta();
      check("rot_winner_ir5", {29'd0, bus.vector_id}, 32'd5);
      check("rot_isr_ir5", {24'd0, bus.isr}, 32'h20);
      inta();

      // Spurious: IR1 in service, IR0 raised then withdrawn before INTA
      do_reset(1'b0);
      bus.ir_in = 8'h02;
      wait_int("spur_ir1_req", 5);
      inta();
      inta();
      bus.ir_in = 8'h03;
      wait_int("spur_ir0_req", 5);
      bus.ir_in = 8'h02;
      ticks(4);
      check("spur_irr_withdrawn", {24'd0, bus.irr}, 32'h00);
      inta();
      check("spur_vid", {29'd0, bus.vector_id}, 32'd7);
      check("spur_isr_unchanged", {24'd0, bus.isr}, 32'h02);
      inta();
      check("spur_vv", {31'd0, bus.vector_valid}, 32'd1);

      // Reset while in ACK1, then AEOI servicing
      do_reset(1'b0);
      bus.ir_in = 8'h08;
      wait_int("rack_req", 5);
      inta();
      check("rack_isr_set", {24'd0, bus.isr}, 32'h08);
      rst_n = 1'b0;
      #1;
      check("rack_async_isr", {24'd0, bus.isr}, 32'h00);
      check("rack_async_irr", {24'd0, bus.irr}, 32'h00);
      check("rack_async_vid", {29'd0, bus.vector_id}, 32'd0);
      check("rack_async_int_req", {31'd0, bus.int_req}, 32'd0);
      check("rack_async_vv", {31'd0, bus.vector_valid}, 32'd0);
      tick();
      rst_n = 1'b1;
      bus.auto_eoi = 1'b1;
      wait_int("aeoi_req", 6);
      inta();
      check("aeoi_idle_after_reset_vv", {31'd0, bus.vector_valid}, 32'd0);
      check("aeoi_vid", {29'd0, bus.vector_id}, 32'd3);
      check("aeoi_isr_set", {24'd0, bus.isr}, 32'h08);
      inta();
      check("aeoi_vv", {31'd0, bus.vector_valid}, 32'd1);
      check("aeoi_isr_cleared", {24'd0, bus.isr}, 32'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
